// File: rtl/seg7_pkg.sv
// Segment constants and nibble decode for the multiplexed seven-segment driver.
// Patterns are active-low, bit order gfedcba in [6:0], decimal point in bit 7.
package seg7_pkg;

   localparam int unsigned SEG_A_BIT  = 0;
   localparam int unsigned SEG_G_BIT  = 6;
   localparam int unsigned SEG_DP_BIT = 7;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Non-BCD nibbles render as a dash so corrupted counter data stays visible.
   function automatic logic [6:0] seg7_pattern(input logic [3:0] nib);
      case (nib)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_DASH;
      endcase
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low gfedcba pattern, with a forced-blank input.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       blank_i,
   output logic [6:0] pat_o
);

   always_comb begin
      pat_o = blank_i ? SEG_BLANK : seg7_pattern(nibble_i);
   end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode seven-segment driver with per-frame input
// snapshot and leading-zero blanking; Sel and Seg are registered.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic [4*DIGITS-1:0]   Bcd,
   input  logic [DIGITS-1:0]     Dp,
   input  logic                  Blank_lz,
   input  logic                  En,
   output logic [DIGITS-1:0]     Sel,
   output logic [7:0]            Seg,
   output logic                  Frame
);

   localparam int unsigned PW = $clog2(SCAN_DIV);
   localparam int unsigned IW = $clog2(DIGITS);

   logic [PW-1:0]       p_q, p_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic [DIGITS-1:0]   dp_q, dp_d;
   logic [DIGITS-1:0]   sel_q, sel_d;
   logic [7:0]          seg_q, seg_d;

   logic                p_last, frame_last, zero_run;
   logic [DIGITS-1:0]   blank_mask;
   logic [3:0]          cur_nib;
   logic                cur_dp, cur_blank;
   logic [6:0]          cur_pat;

   assign p_last     = (p_q == PW'(SCAN_DIV - 1));
   assign frame_last = p_last && (idx_q == IW'(DIGITS - 1));

   always_comb begin
      p_d   = p_last ? '0 : p_q + 1'b1;
      idx_d = idx_q;
      if (p_last) begin
         idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
      bcd_d = frame_last ? Bcd : bcd_q;
      dp_d  = frame_last ? Dp  : dp_q;
   end

   // Walk down from the top digit; digit 0 is excluded so zero still shows "0".
   always_comb begin
      zero_run   = Blank_lz;
      blank_mask = '0;
      for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
         zero_run      = zero_run & (bcd_q[4*k +: 4] == 4'd0);
         blank_mask[k] = zero_run;
      end
   end

   always_comb begin
      cur_nib   = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            cur_nib   = bcd_q[4*i +: 4];
            cur_dp    = dp_q[i];
            cur_blank = blank_mask[i];
         end
      end
   end

   bcd_to_seg7 u_dec (
      .nibble_i (cur_nib),
      .blank_i  (cur_blank),
      .pat_o    (cur_pat)
   );

   always_comb begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
         sel_d[i] = !(En && (idx_q == IW'(i)));
      end
      seg_d = 8'hFF;
      if (En) begin
         seg_d[SEG_G_BIT:SEG_A_BIT] = cur_pat;
         seg_d[SEG_DP_BIT]          = ~cur_dp;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         p_q   <= '0;
         idx_q <= '0;
         bcd_q <= '0;
         dp_q  <= '0;
         sel_q <= '1;
         seg_q <= '1;
      end else begin
         p_q   <= p_d;
         idx_q <= idx_d;
         bcd_q <= bcd_d;
         dp_q  <= dp_d;
         sel_q <= sel_d;
         seg_q <= seg_d;
      end
   end

   assign Sel   = sel_q;
   assign Seg   = seg_q;
   assign Frame = frame_last & ~Rst;

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Multiplexed seven-segment display driver that consumes the packed BCD digit outputs of the cascaded decimal counter chain. It displays them on a common-anode, time-multiplexed LED display. The block steps through the digits at a programmable refresh rate and decodes each BCD nibble to segments. It blanks leading zeros and captures the input once per frame so that counter updates cannot tear a frame.

## Interface
- DIGITS, 4: number of display digits; 2..8.
- SCAN_DIV, 50000: clock cycles each digit stays selected; ≥2.
- Clk  in  1  system clock, all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- Bcd  in  4*DIGITS  packed BCD digits; digit i = Bcd[4i+3:4i]; digit 0 is least significant.
- Dp  in  DIGITS  decimal-point request per digit; 1 = lit.
- Blank_lz  in  1  1 = leading-zero blanking enabled.
- En  in  1  display enable; 0 = all digits dark.
- Sel  out  DIGITS  digit select, one-hot active-low.
- Seg  out  8  segments active-low; Seg[6:0] = g..a, Seg[7] = dp.
- Frame  out  1  one-cycle pulse on each shadow load.

## Operation
- Prescaler p counts 0..SCAN_DIV-1 and wraps to 0. Digit index idx advances by 1 (mod DIGITS) in the cycle where p == SCAN_DIV-1.
- Shadow registers hold copies of Bcd and Dp. They load from the inputs in the cycle where p == SCAN_DIV-1 and idx == DIGITS-1, which is the last cycle of a frame. Frame is asserted in that same cycle.
- The whole next frame displays that snapshot. Input changes at any other time have no effect until the next load.
- Decode rules (gfedcba, active-low):
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
  - Nibbles 10..15 are illegal and show a dash, 0x3F.
  - A blank digit is 0x7F.
- Leading-zero blanking applies when Blank_lz = 1. Digit i (i ≥ 1) is blank if it and every higher shadow digit equal 0. Digit 0 is never blanked, so an all-zero value shows "0".
- Dp is independent of blanking: Seg[7] = ~Dp_shadow[idx].
- When En = 0: Sel = all ones and Seg = 8'hFF. The prescaler, idx and shadow keep running, so re-enabling resumes mid-frame with no resynchronisation.
- Sel and Seg are registered functions of (En, idx, shadow, Blank_lz).

## Timing
- Reset values: Sel = all ones, Seg = 8'hFF, Frame = 0, p = 0, idx = 0, shadow Bcd/Dp = 0.
- Rst takes effect on the clock edge where it is sampled high and overrides every other input. Asserting it mid-frame aborts the frame, and the next cycle shows the reset values.
- Latency: Sel and Seg reflect idx and shadow one cycle after they change. The first edge after Rst deasserts gives Sel = ~1 (digit 0), Seg = 8'hC0 ("0", dp off), since shadow = 0.
- Each digit is active for exactly SCAN_DIV cycles, and a frame is DIGITS*SCAN_DIV cycles.
- Frame pulses every DIGITS*SCAN_DIV cycles. The first pulse comes DIGITS*SCAN_DIV cycles after reset release.
- The shadow values loaded on the Frame cycle reach Seg on the next edge, together with idx = 0.
- Select transitions switch directly from one digit to the next with no dead time. Blanking between digits is out of scope.

## Structure
- Package seg7_pkg holds:
  - the ten digit segment constants plus SEG_DASH and SEG_BLANK;
  - the segment bit-order localparams;
  - a function returning the 7-bit pattern for a 4-bit nibble.
- Sub-module bcd_to_seg7 is a combinational nibble-to-pattern decoder with a blank input. It is instantiated once on the muxed digit.
- The top level contains the prescaler, idx counter, shadow registers, leading-zero mask logic and output registers.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=4.
- Reset release, Bcd=16'h1234, Dp=0, En=1, Blank_lz=0:
  - The first frame shows "0" on digit 0 and 0x40 elsewhere.
  - After Frame, Sel cycles 1110, 1101, 1011, 0111, each held 4 cycles.
  - Seg cycles 0x99, 0xB0, 0xA4, 0xF9 (4, 3, 2, 1 with dp off).
- Tear check with Bcd=16'h0042, Blank_lz=1, Dp=4'b0010:
  - Bcd changes mid-frame; the display is unchanged until the next Frame.
  - Digits 3 and 2 give Seg = 0xFF.
  - Digit 1 gives 0x19 (dp on).
  - Digit 0 gives 0xA4.
- Bcd=16'h0000 with Blank_lz=1: digits 3..1 give 0xFF and digit 0 gives 0xC0.
- Bcd=16'h00AF: digits 1 and 0 give 0xBF (dash, dp off).
- En dropped for 10 cycles: Sel = 4'hF and Seg = 8'hFF. On re-enable, idx continues from the value reached by the free-running count, not from 0.
- Rst asserted at p=2, idx=2:
  - The next cycle shows the reset values and shadow cleared.
  - Frame next pulses 16 cycles after release.
